// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: control, readout and status signals of the performance counter bank
interface perf_counter_bank_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 3
);
    logic              en;
    logic [NUM_CH-1:0] events;
    logic              halt;
    logic              clear;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH:0]   ovf;
    logic              frozen;
    modport master (
        output en, events, halt, clear, rd_req, rd_sel,
        input  rd_valid, rd_data, ovf, frozen
    );
    modport slave (
        input  en, events, halt, clear, rd_req, rd_sel,
        output rd_valid, rd_data, ovf, frozen
    );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event/cycle counters with halt freeze, clear and registered readout.
// Define PERF_CNT_SATURATE_EN to saturate counters instead of wrapping.
module perf_counter_bank #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 3
) (
    input logic clk,
    input logic rst,
    perf_counter_bank_if.slave bus
);
    typedef enum logic {RUN, FROZEN} state_t;
    state_t state, nextState;
    logic [CNT_W-1:0] cntArr [NUM_CH+1];
    logic [NUM_CH:0] ovfVec;
    logic [NUM_CH:0] hits;
    logic countOn;
    logic [CNT_W-1:0] selVal;
    always_ff @(posedge clk) begin
        state <= rst ? RUN : nextState;
    end
    always_comb begin
        nextState = bus.clear ? RUN : (state == RUN && bus.halt) ? FROZEN : state;
    end
    always_comb begin
        bus.frozen = state == FROZEN;
    end
    // top slot is the cycle counter, which counts on every enabled cycle
    assign hits = {1'b1, bus.events};
    assign countOn = state == RUN && bus.en;
    for (genvar i = 0; i <= NUM_CH; i++) begin : gCnt
        logic [CNT_W-1:0] c;
        logic o;
        always_ff @(posedge clk) begin
            if (rst || bus.clear) begin
                c <= '0;
                o <= 1'b0;
            end else if (countOn && hits[i]) begin
`ifdef PERF_CNT_SATURATE_EN
                if (&c) o <= 1'b1;
                else c <= c + CNT_W'(1);
`else
                c <= c + CNT_W'(1);
                if (&c) o <= 1'b1;
`endif
            end
        end
        assign cntArr[i] = c;
        assign ovfVec[i] = o;
    end
    assign bus.ovf = ovfVec;
    // out-of-range selects read as zero
    always_comb begin
        selVal = '0;
        for (int k = 0; k <= NUM_CH; k++)
            selVal = (bus.rd_sel == SEL_W'(k)) ? cntArr[k] : selVal;
    end
    always_ff @(posedge clk) begin
        bus.rd_valid <= !rst && bus.rd_req;
        bus.rd_data  <= (!rst && bus.rd_req) ? selVal : '0;
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and random checks of perf_counter_bank against a behavioural model
module tb_perf_counter_bank;
    localparam int NUM_CH = 6;
    localparam int CNT_W = 4;
    localparam int SEL_W = 3;
    localparam int MAXV = (1 << CNT_W) - 1;
    logic clk = 0;
    logic rst;
    int nAssert = 0;
    int nFail = 0;
    int mCnt [NUM_CH+1];
    bit mOvf [NUM_CH+1];
    bit mFrozen;
    bit expValid;
    int expData;
    perf_counter_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();
    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic bump(input int k);
`ifdef PERF_CNT_SATURATE_EN
        if (mCnt[k] == MAXV) mOvf[k] = 1;
        else mCnt[k]++;
`else
        mCnt[k] = (mCnt[k] + 1) % (MAXV + 1);
        if (mCnt[k] == 0) mOvf[k] = 1;
`endif
    endtask
    task automatic zeroModel();
        for (int k = 0; k <= NUM_CH; k++) begin
            mCnt[k] = 0;
            mOvf[k] = 0;
        end
        mFrozen = 0;
    endtask
    task automatic tick();
        logic [NUM_CH:0] evt;
        logic [NUM_CH:0] ovfExp;
        evt = {1'b1, bus.events};
        expValid = bus.rd_req;
        expData = (int'(bus.rd_sel) <= NUM_CH) ? mCnt[bus.rd_sel] : 0;
        if (rst) begin
            zeroModel();
            expValid = 0;
            expData = 0;
        end else if (bus.clear) zeroModel();
        else if (!mFrozen) begin
            if (bus.en)
                for (int k = 0; k <= NUM_CH; k++)
                    if (evt[k]) bump(k);
            if (bus.halt) mFrozen = 1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k <= NUM_CH; k++) ovfExp[k] = mOvf[k];
        chk("frozen", 32'(bus.frozen), 32'(mFrozen));
        chk("ovf", 32'(bus.ovf), 32'(ovfExp));
        chk("rd_valid", 32'(bus.rd_valid), 32'(expValid));
        if (expValid || rst) chk("rd_data", 32'(bus.rd_data), 32'(expData));
    endtask
    task automatic idle();
        bus.en = 0; bus.events = '0; bus.halt = 0; bus.clear = 0;
        bus.rd_req = 0; bus.rd_sel = '0; rst = 0;
    endtask
    task automatic readExpect(input int sel, input int exp);
        bus.rd_req = 1;
        bus.rd_sel = SEL_W'(sel);
        tick();
        bus.rd_req = 0;
        chk($sformatf("read_sel%0d", sel), 32'(bus.rd_data), 32'(exp));
    endtask
    initial begin
        idle();
        zeroModel();
        rst = 1;
        bus.rd_req = 1; bus.clear = 1; bus.halt = 1; bus.en = 1; bus.events = '1;
        tick();
        tick();
        idle();
        chk("reset_frozen", 32'(bus.frozen), 0);
        chk("reset_valid", 32'(bus.rd_valid), 0);
        // ten counted cycles, halt on the tenth
        bus.en = 1; bus.events = 6'b000101;
        repeat (9) tick();
        bus.halt = 1;
        tick();
        bus.halt = 0;
        chk("halt_frozen", 32'(bus.frozen), 1);
        readExpect(0, 10); readExpect(1, 0); readExpect(2, 10); readExpect(6, 10);
        bus.halt = 1;
        repeat (5) tick();
        bus.halt = 0;
        readExpect(0, 10); readExpect(6, 10);
        readExpect(7, 0);
        // clear while frozen returns the pre-clear value
        bus.clear = 1;
        readExpect(0, 10);
        bus.clear = 0;
        chk("clear_unfreeze", 32'(bus.frozen), 0);
        bus.en = 0;
        readExpect(0, 0);
        bus.events = '1;
        repeat (8) tick();
        readExpect(0, 0); readExpect(5, 0); readExpect(6, 0);
        chk("en0_ovf", 32'(bus.ovf), 0);
        // seventeen events into a 4-bit counter
        bus.en = 1; bus.events = 6'b000001;
        repeat (17) tick();
        bus.en = 0; bus.events = '0;
`ifdef PERF_CNT_SATURATE_EN
        readExpect(0, 15);
`else
        readExpect(0, 1);
`endif
        chk("ovf0", 32'(bus.ovf[0]), 1);
        bus.en = 1; bus.events = '1; bus.halt = 1; bus.clear = 1;
        tick();
        idle();
        chk("halt_clear_frozen", 32'(bus.frozen), 0);
        readExpect(6, 0);
        bus.rd_req = 1; bus.rd_sel = 3'd2;
        tick();
        rst = 1;
        tick();
        idle();
        chk("rst_drop_valid", 32'(bus.rd_valid), 0);
        for (int n = 0; n < 400; n++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            bus.events = NUM_CH'($urandom);
            bus.halt = ($urandom_range(0, 15) == 0);
            bus.clear = ($urandom_range(0, 31) == 0);
            bus.rd_req = ($urandom_range(0, 1) == 1);
            bus.rd_sel = SEL_W'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 6, number of event channels (1..15).
REQ-002 Parameter CNT_W, default 32, counter width in bits (4..32).
REQ-003 Parameter SEL_W, default 3, read-select width; SHALL satisfy 2^SEL_W >= NUM_CH+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  global count enable for cycle counter and all channels.
REQ-007 event  input  NUM_CH  per-channel event strobes, one count per cycle when high.
REQ-008 halt  input  1  freeze request (processor halt reached writeback).
REQ-009 clear  input  1  zero all counters and flags and resume counting.
REQ-010 rd_req  input  1  readout request.
REQ-011 rd_sel  input  SEL_W  readout index; 0..NUM_CH-1 event channels, NUM_CH cycle counter.
REQ-012 rd_valid  output  1  rd_data valid this cycle.
REQ-013 rd_data  output  CNT_W  selected counter value.
REQ-014 ovf  output  NUM_CH+1  sticky overflow flags; bit NUM_CH belongs to the cycle counter.
REQ-015 frozen  output  1  high while in FROZEN state.

Function
REQ-016 Two states, RUN and FROZEN; frozen SHALL be 1 exactly in FROZEN.
REQ-017 RUN: each edge with en=1 SHALL increment the cycle counter by 1 and each channel i with event[i]=1 by 1.
REQ-018 RUN and halt=1 (clear=0): next state FROZEN; events and cycle of the halt cycle SHALL still be counted.
REQ-019 FROZEN: all counters and ovf SHALL hold regardless of en, event, halt.
REQ-020 clear=1 in any state: next state RUN, all counters and ovf SHALL become 0; clear overrides halt and events of the same cycle.
REQ-021 Counting is modulo 2^CNT_W unless the feature of REQ-030 is compiled in; on wrap to 0 the corresponding ovf bit SHALL set and stay set until clear or rst.
REQ-022 rd_req=1 at edge N: rd_valid=1 during cycle N+1 with rd_data equal to the selected counter value before edge N's update.
REQ-023 rd_valid SHALL be 0 in any cycle not preceded by an edge with rd_req=1; back-to-back requests SHALL give back-to-back valid reads.
REQ-024 rd_sel > NUM_CH: rd_valid=1, rd_data=0.
REQ-025 rd_req coincident with clear SHALL return the pre-clear value.
REQ-026 Reads SHALL be serviced identically in RUN and FROZEN and SHALL never alter counter state.

Reset
REQ-027 rst=1 at an edge: state RUN, all counters 0, ovf 0, rd_valid 0, rd_data 0, frozen 0.
REQ-028 rst SHALL override clear, halt, rd_req and events of the same cycle, including mid-readout (pending rd_valid dropped).
REQ-029 After rst deasserts, the first counted cycle is the first edge with rst=0 and en=1.

Configuration
REQ-030 Macro PERF_CNT_SATURATE_EN: when defined, counters SHALL saturate at 2^CNT_W-1 and set their ovf bit on the first increment attempted at that value; when undefined, counters SHALL wrap per REQ-021.

Verification
REQ-031 rst, then en=1 with event=6'b000101 for 10 cycles, halt on 10th -> frozen=1; reads give ch0=10, ch1=0, ch2=10, cycle=10; 5 more cycles of events leave values unchanged.
REQ-032 CNT_W=4, event[0]=1 for 17 cycles, no macro -> ch0=1, ovf[0]=1; with PERF_CNT_SATURATE_EN -> ch0=15, ovf[0]=1.
REQ-033 rd_req with rd_sel=7 (NUM_CH=6 -> cycle counter at 6, 7 out of range) -> next cycle rd_valid=1, rd_data=0.
REQ-034 In FROZEN, clear with rd_req rd_sel=0 (ch0=10) -> rd_data=10, frozen=0 next cycle, subsequent read of ch0=0.
REQ-035 halt and clear same cycle in RUN -> state RUN, all counters 0; rst during a pending read -> rd_valid=0 next cycle.
REQ-036 en=0 with event all-ones for 8 cycles -> all counters remain 0, ovf=0.
